// File: rtl/retire_tracker.sv
// In-order completion tracker that feeds the renamer's commit/discard stream.
// Optional RETIRE_TRACKER_STATS_EN adds saturating commit/discard counters.
module retire_tracker #(
  parameter int DEPTH = 32,
  parameter int PHYS_W = 6,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd_addr,
  input  logic [PHYS_W-1:0] issue_phys_rd_addr,
  output logic              issue_ready,
  output logic [AW-1:0]     issue_id,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_id,
  input  logic              flush,
  output logic              retire_valid,
  output logic              retire_discard,
  output logic [4:0]        retire_rd_addr,
  output logic [PHYS_W-1:0] retire_phys_rd_addr,
  output logic [AW-1:0]     retire_id,
  output logic              draining
`ifdef RETIRE_TRACKER_STATS_EN
  ,
  output logic [31:0]       commit_count,
  output logic [31:0]       discard_count
`endif
);

  typedef enum logic {NORMAL, DRAIN} state_t;

  localparam logic [AW:0] ONE = 1;

  state_t            state, state_nxt;
  logic [AW:0]       head, tail, cnt, remain;
  logic [AW-1:0]     hidx, tidx, wb_off;
  logic [4:0]        rd_q   [DEPTH];
  logic [PHYS_W-1:0] phys_q [DEPTH];
  logic [DEPTH-1:0]  done_q, done_nxt;
  logic              empty, full, pop, fire;

  assign hidx   = head[AW-1:0];
  assign tidx   = tail[AW-1:0];
  assign empty  = head == tail;
  assign full   = (head[AW] != tail[AW]) && (hidx == tidx);
  assign cnt    = tail - head;
  assign wb_off = wb_id - hidx;

  assign draining    = state == DRAIN;
  assign issue_ready = ~full & (state == NORMAL) & ~flush;
  assign issue_id    = tidx;
  assign fire        = issue_valid & issue_ready;

  // Drain pops the head unconditionally; normal mode waits for done.
  assign pop    = ~empty & (draining | done_q[hidx]);
  assign remain = cnt - (pop ? ONE : '0);

  assign retire_valid        = pop & (rd_q[hidx] != 5'd0);
  assign retire_discard      = retire_valid & draining;
  assign retire_rd_addr      = rd_q[hidx];
  assign retire_phys_rd_addr = phys_q[hidx];
  assign retire_id           = hidx;

  always_comb begin
    state_nxt = state;
    unique case (state)
      NORMAL: if (flush && remain != '0) state_nxt = DRAIN;
      DRAIN:  if (remain == '0) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // Pop clear wins so late writebacks to drained slots leave no residue.
  always_comb begin
    done_nxt = done_q;
    if (fire) done_nxt[tidx] = 1'b0;
    if (wb_valid) done_nxt[wb_id] = 1'b1;
    if (pop) done_nxt[hidx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= NORMAL;
      head   <= '0;
      tail   <= '0;
      done_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        phys_q[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (pop) head <= head + ONE;
      if (fire) begin
        tail         <= tail + ONE;
        rd_q[tidx]   <= issue_rd_addr;
        phys_q[tidx] <= issue_phys_rd_addr;
      end
    end
  end

`ifdef RETIRE_TRACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count  <= '0;
      discard_count <= '0;
    end else begin
      if (retire_valid && !retire_discard && commit_count != '1)
        commit_count <= commit_count + 32'd1;
      if (retire_valid && retire_discard && discard_count != '1)
        discard_count <= discard_count + 32'd1;
    end
  end
`endif

  a_issue: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && !flush) |-> issue_ready);

  a_wb: assert property (@(posedge clk) disable iff (rst)
    (wb_valid && !draining) |-> (({1'b0, wb_off} < cnt) && !done_q[wb_id]));

endmodule

// File: tb/tb_retire_tracker.sv
// Bench for retire_tracker: queue-based reference model plus directed cases.
module tb_retire_tracker;
  localparam int DEPTH = 32;
  localparam int PHYS_W = 6;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [4:0]        issue_rd_addr;
  logic [PHYS_W-1:0] issue_phys_rd_addr;
  logic              issue_ready;
  logic [AW-1:0]     issue_id;
  logic              wb_valid;
  logic [AW-1:0]     wb_id;
  logic              flush;
  logic              retire_valid;
  logic              retire_discard;
  logic [4:0]        retire_rd_addr;
  logic [PHYS_W-1:0] retire_phys_rd_addr;
  logic [AW-1:0]     retire_id;
  logic              draining;
`ifdef RETIRE_TRACKER_STATS_EN
  logic [31:0]       commit_count;
  logic [31:0]       discard_count;
`endif

  always #5 clk = ~clk;

  retire_tracker #(.DEPTH(DEPTH), .PHYS_W(PHYS_W)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_rd_addr(issue_rd_addr),
    .issue_phys_rd_addr(issue_phys_rd_addr),
    .issue_ready(issue_ready),
    .issue_id(issue_id),
    .wb_valid(wb_valid),
    .wb_id(wb_id),
    .flush(flush),
    .retire_valid(retire_valid),
    .retire_discard(retire_discard),
    .retire_rd_addr(retire_rd_addr),
    .retire_phys_rd_addr(retire_phys_rd_addr),
    .retire_id(retire_id),
    .draining(draining)
`ifdef RETIRE_TRACKER_STATS_EN
    ,
    .commit_count(commit_count),
    .discard_count(discard_count)
`endif
  );

  typedef struct {
    int id;
    int rd;
    int phys;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  bit   m_drain;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return q.size() < DEPTH && !m_drain && !flush;
  endfunction

  function automatic bit m_pop();
    return q.size() > 0 && (m_drain || q[0].done);
  endfunction

  always @(negedge clk) begin
    bit rv;
    if (chk_en) begin
      rv = m_pop() && q[0].rd != 0;
      chk("issue_ready", issue_ready, m_ready());
      chk("issue_id", issue_id, m_tail);
      chk("draining", draining, m_drain);
      chk("retire_valid", retire_valid, rv);
      if (rv) begin
        chk("retire_discard", retire_discard, m_drain);
        chk("retire_rd", retire_rd_addr, q[0].rd);
        chk("retire_phys", retire_phys_rd_addr, q[0].phys);
        chk("retire_id", retire_id, q[0].id);
      end
    end
  end

  always @(posedge clk) begin
    bit p, rdy;
    int rem;
    if (rst) begin
      q.delete();
      m_tail = 0;
      m_drain = 0;
    end else begin
      p = m_pop();
      rdy = m_ready();
      if (wb_valid)
        foreach (q[i]) if (q[i].id == int'(wb_id)) q[i].done = 1;
      if (p) void'(q.pop_front());
      rem = q.size();
      if (issue_valid && rdy) begin
        q.push_back('{m_tail, int'(issue_rd_addr), int'(issue_phys_rd_addr), 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_drain = m_drain ? (rem != 0) : (flush && rem != 0);
    end
  end

  task automatic drive(bit iv, int rd, int ph, bit wv, int wid, bit fl);
    issue_valid = iv;
    issue_rd_addr = rd[4:0];
    issue_phys_rd_addr = ph[PHYS_W-1:0];
    wb_valid = wv;
    wb_id = wid[AW-1:0];
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(bit iv, int rd, int ph, bit wv, int wid, bit fl);
    drive(iv, rd, ph, wv, wid, fl);
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic scen1(int b);
    drive(1, 5, 33, 0, 0, 0);
    #1 chk("s1_issue_id0", issue_id, b);
    tick();
    step(1, 0, 0, 0, 0, 0);
    step(1, 7, 34, 0, 0, 0);
    step(0, 0, 0, 1, b + 2, 0);
    step(0, 0, 0, 1, b + 1, 0);
    step(0, 0, 0, 1, b, 0);
    idle();
    #1;
    chk("s1_rv_a", retire_valid, 1);
    chk("s1_id_a", retire_id, b);
    chk("s1_phys_a", retire_phys_rd_addr, 33);
    chk("s1_disc_a", retire_discard, 0);
    tick();
    #1 chk("s1_silent", retire_valid, 0);
    tick();
    #1;
    chk("s1_rv_c", retire_valid, 1);
    chk("s1_id_c", retire_id, b + 2);
    chk("s1_phys_c", retire_phys_rd_addr, 34);
    tick();
    #1 chk("s1_after", retire_valid, 0);
    tick();
  endtask

  task automatic scen3(int b);
    for (int k = 0; k < 4; k++) step(1, k + 1, 40 + k, 0, 0, 0);
    step(0, 0, 0, 1, b + 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("s3_flush_rdy", issue_ready, 0);
    chk("s3_flush_drn", draining, 0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("s3_drn", draining, 1);
      chk("s3_rv", retire_valid, 1);
      chk("s3_disc", retire_discard, 1);
      chk("s3_phys", retire_phys_rd_addr, 40 + k);
      tick();
    end
    #1;
    chk("s3_end_drn", draining, 0);
    chk("s3_end_rdy", issue_ready, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cand[$];
    int wbp;
    bit fl, iv, wv;
    int wid;
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
    chk_en = 1;
    #1;
    chk("rst_ready", issue_ready, 1);
    chk("rst_id", issue_id, 0);
    chk("rst_rv", retire_valid, 0);
    chk("rst_disc", retire_discard, 0);
    chk("rst_drn", draining, 0);
    chk("rst_phys", retire_phys_rd_addr, 0);
    tick();

    scen1(0);
    scen3(3);
`ifdef RETIRE_TRACKER_STATS_EN
    chk("commit_count", commit_count, 2);
    chk("discard_count", discard_count, 4);
`endif

    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, i % 31 + 1, i, 0, 0, 0);
    idle();
    #1;
    chk("s2_full_rdy", issue_ready, 0);
    chk("s2_full_id", issue_id, 0);
    tick();
    step(0, 0, 0, 1, 0, 0);
    idle();
    #1;
    chk("s2_ret_rv", retire_valid, 1);
    chk("s2_ret_id", retire_id, 0);
    chk("s2_ret_rdy", issue_ready, 0);
    tick();
    drive(1, 9, 50, 0, 0, 0);
    #1;
    chk("s2_wrap_rdy", issue_ready, 1);
    chk("s2_wrap_id", issue_id, 0);
    tick();
    idle();
    #1;
    chk("s2_refull_rdy", issue_ready, 0);
    chk("s2_refull_id", issue_id, 1);
    tick();

    do_reset();
    step(1, 2, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    drive(1, 3, 3, 0, 0, 1);
    #1 chk("s4_flush_rdy", issue_ready, 0);
    tick();
    idle();
    #1;
    chk("s4_id", issue_id, 1);
    chk("s4_drn", draining, 0);
    chk("s4_rdy", issue_ready, 1);
    tick();

    for (int k = 0; k < 5; k++) step(1, k + 1, 10 + k, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("s5_drn_mid", draining, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("s5_drn", draining, 0);
    chk("s5_rv", retire_valid, 0);
    chk("s5_id", issue_id, 0);
    chk("s5_rdy", issue_ready, 1);
    tick();

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      wbp = ((n / 400) % 2 != 0) ? 15 : 70;
      fl = $urandom_range(0, 99) < 3;
      flush = fl;
      iv = (m_ready() || fl) && $urandom_range(0, 99) < 60;
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(q[i].id);
      wv = cand.size() > 0 && $urandom_range(0, 99) < wbp;
      wid = wv ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      drive(iv, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
            $urandom_range(0, 63), wv, wid, fl);
      tick();
    end
    idle();
    tick();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
